// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, stall/flush/forward controls out.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             PCSrcE, MemAccessM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE, RegWriteM, RegWriteW,
        output PCSrcE, MemAccessM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  MemErr, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE, RegWriteM, RegWriteW,
        input  PCSrcE, MemAccessM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output MemErr, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Forwarding, load-use/branch hazard and data-memory wait controller
// for the 5-stage pipeline, with saturating debug counters.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_t;

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             lw_stall;
    logic             mem_stall;
    logic             stall_fd;
    logic             flush_d;

    // Memory-stage result is younger, so it wins over writeback.
    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
            hz.ForwardAE = 2'b01;
    end

    always_comb begin
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
            hz.ForwardBE = 2'b01;
    end

    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                      (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

    always_comb begin
        mem_stall = 1'b1;
        case (state)
            RUN:      mem_stall = hz.MemAccessM && !hz.MemReadyM;
            MEM_WAIT: mem_stall = !hz.MemReadyM;
            default:  mem_stall = 1'b1;
        endcase
    end

    assign stall_fd = lw_stall | mem_stall;
    assign flush_d  = !mem_stall && hz.PCSrcE;

    assign hz.StallF     = stall_fd;
    assign hz.StallD     = stall_fd;
    assign hz.StallE     = mem_stall;
    assign hz.StallM     = mem_stall;
    assign hz.FlushW     = mem_stall;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = !mem_stall && (lw_stall | hz.PCSrcE);
    assign hz.MemErr     = mem_err;
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_fd && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_d && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            case (state)
                RUN: begin
                    if (hz.MemAccessM && !hz.MemReadyM) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (hz.MemReadyM) begin
                        state <= RUN;
                    end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    // Only reset leaves the error freeze.
                    state   <= ERR;
                    mem_err <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected outputs queued at drive, popped at sample.
module tb_hazard_stall_ctrl;
    localparam int CW = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          sf, sd, se, sm;
        logic          fd, fe, fw, err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    obs_t q[$];
    obs_t got, exp_o;

    int m_st, m_cnt, m_err, m_sc, m_fc;

    hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_stall_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .hz (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t model_out();
        obs_t o;
        logic lw, ms;
        o = '0;
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == bus.Rs1E) o.fa = 2'b10;
        else if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == bus.Rs1E) o.fa = 2'b01;
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == bus.Rs2E) o.fb = 2'b10;
        else if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == bus.Rs2E) o.fb = 2'b01;
        lw = (bus.ResultSrcE == 2'b01) && bus.RdE != 0 &&
             (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        ms = (m_st == 0 && bus.MemAccessM && !bus.MemReadyM) ||
             (m_st == 1 && !bus.MemReadyM) || (m_st == 2);
        o.sf  = lw | ms;
        o.sd  = lw | ms;
        o.se  = ms;
        o.sm  = ms;
        o.fw  = ms;
        o.fe  = !ms && (lw | bus.PCSrcE);
        o.fd  = !ms && bus.PCSrcE;
        o.err = (m_err != 0);
        o.sc  = CW'(m_sc);
        o.fc  = CW'(m_fc);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.fa  = bus.ForwardAE;
        o.fb  = bus.ForwardBE;
        o.sf  = bus.StallF;
        o.sd  = bus.StallD;
        o.se  = bus.StallE;
        o.sm  = bus.StallM;
        o.fd  = bus.FlushD;
        o.fe  = bus.FlushE;
        o.fw  = bus.FlushW;
        o.err = bus.MemErr;
        o.sc  = bus.StallCount;
        o.fc  = bus.FlushCount;
        return o;
    endfunction

    task automatic model_tick();
        obs_t o;
        o = model_out();
        if (o.sf && m_sc != (1 << CW) - 1) m_sc++;
        if (o.fd && m_fc != (1 << CW) - 1) m_fc++;
        case (m_st)
            0: if (bus.MemAccessM && !bus.MemReadyM) begin
                m_st  = 1;
                m_cnt = 1;
            end
            1: if (bus.MemReadyM) m_st = 0;
               else if (m_cnt == TO) begin
                   m_st  = 2;
                   m_err = 1;
               end else m_cnt++;
            default: ;
        endcase
    endtask

    task automatic clear_inputs();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0; bus.ResultSrcE = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0; bus.PCSrcE = 0;
        bus.MemAccessM = 0; bus.MemReadyM = 0;
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        #1;
        rst = 1'b1;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.MemAccessM = 1'b1;
        advance();
        advance();
        clear_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        q.push_back(model_out());
        got = sample();
        exp_o = q.pop_front();
        checks++;
        if (got !== exp_o || got !== '0) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", got, exp_o);
        end
        @(negedge clk);
        rst = 1'b1;
        advance();
    endtask

    task automatic test_forwarding();
        do_reset();
        bus.Rs1E = 5; bus.RdM = 5; bus.RegWriteM = 1;
        bus.RdW = 5; bus.RegWriteW = 1; bus.Rs2E = 5;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) bus.RegWriteM = 0;
            if (i == 2) begin
                bus.Rs2E = 0;
                bus.RdW = 0;
            end
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL fwd%0d got=%h exp=%h", i, got, exp_o);
            end
            checks++;
            if (i == 0 && got.fa !== 2'b10 || i == 1 && got.fa !== 2'b01 ||
                i == 2 && got.fb !== 2'b00) begin
                errors++;
                $display("FAIL fwd_const%0d fa=%b fb=%b", i, got.fa, got.fb);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ResultSrcE = 2'b01; bus.RdE = 3; bus.Rs2D = 3;
        q.push_back(model_out());
        @(negedge clk);
        got = sample();
        exp_o = q.pop_front();
        checks++;
        if (got !== exp_o || {got.sf, got.sd, got.fe, got.se, got.fd} !== 5'b11100) begin
            errors++;
            $display("FAIL load_use got=%h exp=%h", got, exp_o);
        end
        advance();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.StallCount !== CW'(1)) begin
            errors++;
            $display("FAIL load_use_cnt got=%0d exp=1", bus.StallCount);
        end
        advance();
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.PCSrcE = 1;
            if (i == 1) begin
                bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs1D = 7;
            end
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL branch%0d got=%h exp=%h", i, got, exp_o);
            end
            checks++;
            if (got.fd !== 1'b1 || got.fe !== 1'b1 || got.sf !== (i == 1) ||
                got.sd !== (i == 1) || got.se !== 1'b0) begin
                errors++;
                $display("FAIL branch_const%0d got=%h", i, got);
            end
            advance();
            clear_inputs();
            @(negedge clk);
            checks++;
            if (bus.FlushCount !== CW'(i + 1)) begin
                errors++;
                $display("FAIL branch_cnt%0d got=%0d exp=%0d", i, bus.FlushCount, i + 1);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.MemAccessM = 1;
        bus.PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            bus.MemReadyM = (i == 3);
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o ||
                {got.sf, got.sd, got.se, got.sm, got.fw} !== {5{i != 3}} ||
                got.fd !== (i == 3)) begin
                errors++;
                $display("FAIL mem_wait%0d got=%h exp=%h", i, got, exp_o);
            end
            advance();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.StallCount !== CW'(3) || bus.StallE !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_cnt got=%0d exp=3", bus.StallCount);
        end
        advance();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.MemAccessM = 1;
        for (int i = 0; i < TO + 4; i++) begin
            if (i == TO + 2) bus.MemReadyM = 1;
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o || got.se !== 1'b1 || got.err !== (i > TO)) begin
                errors++;
                $display("FAIL timeout%0d got=%h exp=%h", i, got, exp_o);
            end
            advance();
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.MemErr !== 1'b0 || bus.StallCount !== '0 || bus.FlushCount !== '0) begin
            errors++;
            $display("FAIL timeout_rst err=%b sc=%0d", bus.MemErr, bus.StallCount);
        end
        model_reset();
        clear_inputs();
        #1 rst = 1'b1;
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ResultSrcE = 2'b01; bus.RdE = 9; bus.Rs1D = 9;
        for (int i = 0; i < 20; i++) begin
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL sat%0d got=%h exp=%h", i, got, exp_o);
            end
            advance();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.StallCount !== CW'(15)) begin
            errors++;
            $display("FAIL sat_cnt got=%0d exp=15", bus.StallCount);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            bus.Rs1D = 5'($urandom_range(0, 3));
            bus.Rs2D = 5'($urandom_range(0, 3));
            bus.Rs1E = 5'($urandom_range(0, 3));
            bus.Rs2E = 5'($urandom_range(0, 3));
            bus.RdE = 5'($urandom_range(0, 3));
            bus.RdM = 5'($urandom_range(0, 3));
            bus.RdW = 5'($urandom_range(0, 3));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.RegWriteM = 1'($urandom_range(0, 1));
            bus.RegWriteW = 1'($urandom_range(0, 1));
            bus.PCSrcE = 1'($urandom_range(0, 1));
            bus.MemAccessM = 1'($urandom_range(0, 1));
            bus.MemReadyM = ($urandom_range(0, 3) != 0);
            q.push_back(model_out());
            @(negedge clk);
            got = sample();
            exp_o = q.pop_front();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL b2b%0d got=%h exp=%h", i, got, exp_o);
            end
            advance();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RISC-V pipeline (fetch, decode, execute, memory, writeback).
- Generates forwarding selects for the execute-stage ALU operands.
- Generates stall and flush enables for the pipeline registers.
- Freezes the whole pipeline while a data-memory access waits for ready, with a timeout error state.
- Keeps saturating stall and flush event counters for debug.

Parameters:
CNT_W, 16, width of the stall and flush event counters
MEM_TIMEOUT, 8, cycles spent in MEM_WAIT before entering ERR (valid range 1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 of the instruction in decode
Rs2D  in  5  rs2 of the instruction in decode
Rs1E  in  5  rs1 of the instruction in execute
Rs2E  in  5  rs2 of the instruction in execute
RdE  in  5  destination register in execute
RdM  in  5  destination register in memory
RdW  in  5  destination register in writeback
ResultSrcE  in  2  result select in execute; 2'b01 = load
RegWriteM  in  1  memory-stage instruction writes the register file
RegWriteW  in  1  writeback-stage instruction writes the register file
PCSrcE  in  1  branch/jump taken, resolved in execute
MemAccessM  in  1  memory stage issues a data-memory load or store
MemReadyM  in  1  data memory completes the access this cycle
ForwardAE  out  2  ALU operand A select: 00 = register file, 01 = ResultW, 10 = ALU_ResultM
ForwardBE  out  2  ALU operand B select, same encoding as ForwardAE
StallF  out  1  hold PC
StallD  out  1  hold the IF/ID register
StallE  out  1  hold the ID/EX register
StallM  out  1  hold the EX/MEM register
FlushD  out  1  clear the IF/ID register
FlushE  out  1  clear the ID/EX register (insert bubble)
FlushW  out  1  clear the MEM/WB register (bubble into writeback)
MemErr  out  1  sticky memory timeout flag
StallCount  out  CNT_W  cycles with StallF=1, saturating
FlushCount  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait counter=0, MemErr=0, StallCount=0, FlushCount=0. With all inputs at 0, every combinational output is 0.
- Forwarding (combinational), operand A:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00.
  - The memory-stage match wins when both stages match. ForwardBE is identical using Rs2E. x0 is never forwarded.
- Load-use (combinational): lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall (combinational) is asserted when:
  - state==RUN && MemAccessM && !MemReadyM; or
  - state==MEM_WAIT && !MemReadyM; or
  - state==ERR.
- Output rules:
  - StallF = StallD = lwStall | memStall.
  - StallE = StallM = memStall.
  - FlushW = memStall.
  - FlushE = !memStall && (lwStall | PCSrcE).
  - FlushD = !memStall && PCSrcE.
- Priority:
  - memStall freezes everything and overrides all flushes; the branch is re-evaluated after release because execute is held.
  - When lwStall and PCSrcE occur together, FlushD and FlushE are both 1 and StallF/StallD are also 1. The PC mux prioritises PCSrcE, so the branch target still loads into the PC.
- FSM:
  - RUN -> MEM_WAIT when MemAccessM && !MemReadyM; wait counter loads 1.
  - MEM_WAIT -> RUN when MemReadyM=1. memStall is 0 in that same cycle, so the pipeline advances on the ready cycle with zero extra latency.
  - MEM_WAIT with !MemReadyM: wait counter increments. When the counter equals MEM_TIMEOUT, the next state is ERR.
  - ERR: MemErr=1, permanent freeze; exits only through reset.
  - A single-cycle access (MemReadyM=1 on its first cycle) never leaves RUN.
- Counters (registered, update on the clock edge):
  - StallCount += 1 in each cycle where StallF=1.
  - FlushCount += 1 in each cycle where FlushD=1.
  - Both saturate at all-ones with no wrap.
- Reset asserted mid-wait returns to RUN immediately (asynchronous) and clears MemErr and both counters.

Test Plan:
1. Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set Rs2E=0, RdW=0 -> ForwardBE=00.
2. Load-use: ResultSrcE=01, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1, StallE=0, FlushD=0 for one cycle; StallCount 0->1.
3. Taken branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, stalls 0, FlushCount 0->1. Combined with load-use -> FlushD=FlushE=StallF=StallD=1.
4. Memory wait: MemAccessM=1, MemReadyM=0 for 3 cycles, then 1 -> all four stalls and FlushW are 1 for exactly 3 cycles; state returns to RUN on the 4th cycle with stalls 0; StallCount=3.
5. Timeout (MEM_TIMEOUT=8): MemReadyM held 0 -> ERR entered after 8 wait cycles, MemErr=1 and stalls remain 1 forever. Raising MemReadyM has no effect; pulsing rst=0 clears MemErr and the counters asynchronously.
6. Saturation (CNT_W=4): hold lwStall for 20 cycles -> StallCount stops at 15 and does not wrap.
